// File: rtl/eca_engine.sv
// eca_engine: elementary cellular automaton engine.
//
// Holds a NUM_CELLS-bit cell row and evolves it under any of the 256
// Wolfram rules, chosen at run time. The row loads one byte at a time.
// A run lasts either a set number of generations or until stop. The row
// is read out through a registered byte window.
//
// Optional feature macro: ECA_WRAP_EN
//   defined   - toroidal row: cell 0 and cell NUM_CELLS-1 are neighbours.
//   undefined - neighbours outside the row read as 0.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   load_valid    shift load_data into the top of the row (IDLE only)
//   load_data     byte to load
//   rule          Wolfram rule number, latched on an accepted start
//   steps         number of generations for the run, 0 = free-run
//   start         begin a run (IDLE only)
//   stop          abort a run (RUN only); takes priority over advance
//   advance       in RUN, compute one generation this cycle
//   busy          high while in RUN (registered)
//   done          one-cycle pulse when a run ends (registered)
//   gen_count     generations computed since the last start
//   win_sel       byte window select
//   win_data      registered cells[win_sel*8 +: 8]
module eca_engine #(
  parameter  int NUM_CELLS = 64,
  parameter  int GEN_W     = 16,
  localparam int SEL_W     = $clog2(NUM_CELLS / 8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic [7:0]       rule,
  input  logic [GEN_W-1:0] steps,
  input  logic             start,
  input  logic             stop,
  input  logic             advance,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  input  logic [SEL_W-1:0] win_sel,
  output logic [7:0]       win_data
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CELLS-1:0] cells_q, cells_d;
  logic [NUM_CELLS-1:0] cells_evolved;
  logic [7:0]           rule_q, rule_d;
  logic [GEN_W-1:0]     rem_q, rem_d;
  logic [GEN_W-1:0]     gen_q, gen_d;
  logic                 done_d;
  logic                 busy_q, done_q;
  logic [7:0]           win_q;

  // Row padded by one neighbour at each end: ext[i+1] is cell i, ext[0]
  // is the right neighbour of cell 0, ext[NUM_CELLS+1] the left neighbour
  // of cell NUM_CELLS-1.
  logic [NUM_CELLS+1:0] ext;

  always_comb begin
`ifdef ECA_WRAP_EN
    ext = {cells_q[0], cells_q, cells_q[NUM_CELLS-1]};
`else
    ext = {1'b0, cells_q, 1'b0};
`endif
    cells_evolved = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cells_evolved[i] = rule_q[ext[i+2 -: 3]];
    end
  end

  always_comb begin
    state_d = state_q;
    cells_d = cells_q;
    rule_d  = rule_q;
    rem_d   = rem_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          cells_d = {load_data, cells_q[NUM_CELLS-1:8]};
        end
        if (start) begin
          rule_d  = rule;
          rem_d   = steps;
          gen_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (advance) begin
          cells_d = cells_evolved;
          gen_d   = gen_q + GEN_W'(1);
          if (rem_q != '0) begin
            rem_d = rem_q - GEN_W'(1);
          end
          // rem of 0 means free-run, so only a count of exactly 1 ends the run.
          if (rem_q == GEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cells_q <= '0;
      rule_q  <= '0;
      rem_q   <= '0;
      gen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      rule_q  <= rule_d;
      rem_q   <= rem_d;
      gen_q   <= gen_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= done_d;
      win_q   <= cells_q[{win_sel, 3'b000} +: 8];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_q;
  assign win_data  = win_q;

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine (NUM_CELLS=64). Stimulus pushes expected
// window reads and expected run results into queues; a monitor pops and
// compares whenever a read lands or the DUT pulses done.
module tb_eca_engine;

  localparam int NC = 64;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [7:0]    load_data;
  logic [7:0]    rule;
  logic [GW-1:0] steps;
  logic          start;
  logic          stop;
  logic          advance;
  logic          busy;
  logic          done;
  logic [GW-1:0] gen_count;
  logic [2:0]    win_sel;
  logic [7:0]    win_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic          rd_req = 1'b0;
  logic          rd_vld = 1'b0;
  logic [7:0]    rd_exp_q[$];
  string         rd_name_q[$];
  logic [GW-1:0] done_exp_q[$];

  eca_engine #(.NUM_CELLS(NC), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .rule(rule), .steps(steps), .start(start), .stop(stop), .advance(advance),
    .busy(busy), .done(done), .gen_count(gen_count), .win_sel(win_sel),
    .win_data(win_data)
  );

  always #5 clk = ~clk;

  // A read request issued before an edge is answered by win_data after it.
  always @(posedge clk) rd_vld <= rd_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_vld) begin
        if (rd_exp_q.size() == 0) begin
          chk("rd_queue_underflow", 1, 0);
        end else begin
          automatic logic [7:0] e  = rd_exp_q.pop_front();
          automatic string      nm = rd_name_q.pop_front();
          chk(nm, {24'd0, win_data}, {24'd0, e});
        end
      end
      if (done) begin
        if (done_exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          automatic logic [GW-1:0] g = done_exp_q.pop_front();
          chk("done_gen_count", {16'd0, gen_count}, {16'd0, g});
          chk("done_busy_low", {31'd0, busy}, 0);
        end
      end
    end
  end

  task automatic rd(input int sel, input logic [7:0] exp, input string nm);
    @(negedge clk);
    win_sel = sel[2:0];
    rd_req  = 1'b1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Seed: 0x01 first, then seven 0x00 -> only cell 0 set.
  task automatic load_seed();
    for (int i = 0; i < NC / 8; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = (i == 0) ? 8'h01 : 8'h00;
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic run(input logic [7:0] r, input logic [GW-1:0] n, input string nm);
    @(negedge clk);
    rule = r; steps = n; start = 1'b1; advance = 1'b1;
    done_exp_q.push_back(n);
    @(negedge clk);
    start = 1'b0;
    wait_idle(nm);
    advance = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; rule = '0; steps = '0;
    start = 1'b0; stop = 1'b0; advance = 1'b0; win_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_gen", {16'd0, gen_count}, 0);
    chk("rst_win", {24'd0, win_data}, 0);
    reset = 1'b0;

    // Load and read back every window.
    load_seed();
    for (int s = 0; s < NC / 8; s++) rd(s, (s == 0) ? 8'h01 : 8'h00, "win_load");

    // Rule 110, 3 steps, streaming window 0 across the run.
    @(negedge clk);
    rule = 8'd110; steps = 16'd3; start = 1'b1; advance = 1'b1;
    win_sel = 3'd0; rd_req = 1'b1;
    done_exp_q.push_back(16'd3);
    rd_exp_q.push_back(8'h01); rd_name_q.push_back("r110_e0");
    @(negedge clk);
    start = 1'b0;
    chk("r110_busy", {31'd0, busy}, 1);
    rd_exp_q.push_back(8'h01); rd_name_q.push_back("r110_g0");
    @(negedge clk);
    rd_exp_q.push_back(8'h03); rd_name_q.push_back("r110_g1");
    @(negedge clk);
    rd_exp_q.push_back(8'h07); rd_name_q.push_back("r110_g2");
    @(negedge clk);
    advance = 1'b0;
    rd_exp_q.push_back(8'h0D); rd_name_q.push_back("r110_g3");
    @(negedge clk);
    rd_req = 1'b0;
    chk("r110_idle", {31'd0, busy}, 0);
    rd(1, 8'h00, "r110_win1");

    // Rule 90, single step: edge neighbour depends on wrap.
    load_seed();
    run(8'd90, 16'd1, "r90");
    rd(0, 8'h02, "r90_win0");
`ifdef ECA_WRAP_EN
    rd(7, 8'h80, "r90_win7");
`else
    rd(7, 8'h00, "r90_win7");
`endif

    // Rule 170 shifts the row up one cell per generation; free-run with
    // advance on every other cycle, then stop.
    load_seed();
    @(negedge clk);
    rule = 8'd170; steps = 16'd0; start = 1'b1; advance = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start   = 1'b0;
      advance = (k % 2 == 0);
    end
    @(negedge clk);
    advance = 1'b0; stop = 1'b1;
    done_exp_q.push_back(16'd10);
    @(negedge clk);
    stop = 1'b0; advance = 1'b1;
    chk("free_busy_low", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("free_gen_hold", {16'd0, gen_count}, 10);
    rd(1, 8'h04, "free_win1");
    rd(0, 8'h00, "free_win0");
    advance = 1'b0;

    // Stop together with advance on the 3rd generation edge.
    load_seed();
    @(negedge clk);
    rule = 8'd170; steps = 16'd5; start = 1'b1; advance = 1'b1;
    done_exp_q.push_back(16'd2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; advance = 1'b0;
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_gen", {16'd0, gen_count}, 2);
    rd(0, 8'h04, "stop_win0");

    // Reset mid-run.
    load_seed();
    @(negedge clk);
    rule = 8'd170; steps = 16'd0; start = 1'b1; advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_gen", {16'd0, gen_count}, 0);
    chk("mrst_win", {24'd0, win_data}, 0);
    reset = 1'b0; advance = 1'b0;
    repeat (3) @(negedge clk);
    rd(0, 8'h00, "mrst_row_clear");
    load_seed();
    run(8'd170, 16'd2, "post_rst");
    rd(0, 8'h04, "post_rst_win0");

    repeat (4) @(negedge clk);
    chk("rd_queue_empty", rd_exp_q.size(), 0);
    chk("done_queue_empty", done_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/eca_engine.md
# eca_engine

Parametrised elementary cellular automaton engine. It holds a NUM_CELLS-bit cell row and evolves it under any of the 256 Wolfram rules, selected at run time. Rows load byte-serially; runs cover a bounded or unbounded number of generations under a start/stop/advance handshake. The row reads out through a registered byte window. It replaces the fixed-rule, free-running automaton in the top-level wrapper and drives the 8-bit output pins from `win_data`.

## Interface
Parameters:
- `NUM_CELLS`, 64: row width. Must be a multiple of 8 and at least 16.
- `GEN_W`, 16: width of the step and generation counters.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `load_valid`  in  1  shift `load_data` into the row; honoured in IDLE only.
- `load_data`  in  8  byte to load.
- `rule`  in  8  rule number; latched on accepted `start`.
- `steps`  in  GEN_W  generation count for the run; 0 = free-run until `stop`. Latched on accepted `start`.
- `start`  in  1  begin a run; honoured in IDLE only.
- `stop`  in  1  abort a run; honoured in RUN only.
- `advance`  in  1  in RUN, evolve one generation this cycle when high.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run ends.
- `gen_count`  out  GEN_W  generations computed since the last `start`.
- `win_sel`  in  clog2(NUM_CELLS/8)  byte window select.
- `win_data`  out  8  registered value of `cells[win_sel*8 +: 8]`.

## Operation
- State machine has two states, IDLE and RUN.
  - IDLE to RUN on `start`.
  - RUN to IDLE on `stop`, or on completion of the final generation when `steps` is non-zero.
- Load, in IDLE only, on `load_valid`: `cells <= {load_data, cells[NUM_CELLS-1:8]}`.
  - After NUM_CELLS/8 loads, the first byte loaded sits in `cells[7:0]`.
  - `load_valid` outside IDLE is ignored.
- Accepted `start`:
  - Latches `rule` into `rule_q`.
  - Latches `steps` into the remaining counter `rem`.
  - Clears `gen_count`.
  - Row is unchanged.
- Each RUN cycle with `advance`=1 and `stop`=0:
  - Every cell updates in parallel: `next[i] = rule_q[{cells[i+1], cells[i], cells[i-1]}]`. Edge neighbours are defined under Configuration.
  - `gen_count` increments, wrapping modulo 2^GEN_W.
  - If `rem` != 0, `rem` decrements.
- Completion: if `rem` is 1 at a generation edge, that edge also moves to IDLE and sets `done`.
- `steps`=0: free-run; the run ends only on `stop`.
- `stop` in RUN:
  - No generation is computed that cycle.
  - Moves to IDLE and pulses `done`.
  - `stop` takes priority over `advance`.
- `advance`=0 in RUN: row and counters hold.
- Ignored inputs: `start` in RUN; `stop` in IDLE. `start` and `load_valid` together in IDLE: both take effect, the load shifts and the run arms.
- `rule_q` is stable for the whole run; `rule` changes mid-run have no effect.

## Timing
- All state is updated on the `clk` rising edge.
- Reset values:
  - `cells` = 0.
  - `rule_q` = 0.
  - `rem` = 0.
  - `gen_count` = 0.
  - state = IDLE.
  - `busy` = 0.
  - `done` = 0.
  - `win_data` = 0.
- Reset mid-run aborts with no `done` pulse.
- `start` sampled at edge E0. With `advance` held high, generations land at edges E1..EN for `steps`=N.
  - `busy` is high after E0 and low after EN.
  - `done` is high for the single cycle following EN.
- `win_data` has 1-cycle latency from both `win_sel` and `cells`.
- `busy` and `done` are registered. `gen_count` is a direct register output.

## Configuration
- `ECA_WRAP_EN` defined: toroidal row.
  - Left neighbour of cell NUM_CELLS-1 is cell 0.
  - Right neighbour of cell 0 is cell NUM_CELLS-1.
- `ECA_WRAP_EN` undefined: both out-of-row neighbours read as 0.

## Test plan
All scenarios use NUM_CELLS=64.
- Load 0x01 then seven 0x00; `win_sel`=0 → `win_data`=0x01 one cycle later; all other windows 0x00.
- Seed 0x01, `rule`=110, `steps`=3, `advance`=1, wrap enabled → `cells[7:0]` is 0x03, 0x07, 0x0D; `gen_count`=3; `done` pulses once after E3.
- Seed 0x01, `rule`=90, `steps`=1:
  - With `ECA_WRAP_EN`: bits 1 and 63 set.
  - Without it: only bit 1 set.
- `steps`=0, `advance` toggled every other cycle for 20 cycles, then `stop` → `gen_count`=10; `done` pulses once; row frozen afterwards.
- `steps`=5; assert `stop` and `advance` together at the 3rd generation edge → `gen_count`=2; `done` pulses; `busy` is low next cycle.
- Reset asserted mid-run → all outputs 0 and state IDLE on the next cycle; no `done` pulse; a subsequent load and run behave normally.
